// File: rtl/instr_encoder.sv
// Symbolic-instruction to MIPS word encoder that streams each encoded word into
// instruction memory at consecutive word addresses, one handshake per word.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [ADDR_W-1:0] in_target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, FULL = 2'd2} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg;
  logic [31:0]         wdata_reg;
  logic                err_reg;

  logic [ADDR_W:0]     pc_inc;
  logic                last_word;
  logic [ADDR_W:0]     diff;
  logic signed [31:0]  diff_ext;
  logic                off_fits;
  logic [31:0]         enc_word;
  logic                enc_ok;
  logic                accept;

  assign pc_inc    = {1'b0, pc_reg} + 1'b1;
  assign last_word = (pc_inc == (ADDR_W+1)'(DEPTH));

  // beq offset is relative to the word after the branch; computed one bit wider
  // than the address so the full range of target-(pc+1) is representable.
  assign diff     = {1'b0, in_target} - pc_inc;
  assign diff_ext = 32'(signed'(diff));
  assign off_fits = (diff_ext[31:15] == '0) || (diff_ext[31:15] == '1);

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b1;
    case (in_kind)
      4'd0: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      4'd1: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      4'd2: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
      4'd3: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
      4'd4: enc_word = {6'b001101, in_rs, in_rt, in_imm};
      4'd5: enc_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd6: enc_word = {6'b101011, in_rs, in_rt, in_imm};
      4'd7: begin
        enc_word = {6'b000100, in_rs, in_rt, diff_ext[15:0]};
        enc_ok   = off_fits;
      end
      4'd8: enc_word = {6'b000010, 26'(in_target)};
      4'd9: enc_word = {6'b001000, in_rs, in_rt, in_imm};
      default: enc_ok = 1'b0;
    endcase
  end

  assign accept = (state_reg == IDLE) && in_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; clear overrides everything else
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid && enc_ok) state_next = EMIT;
      EMIT:    if (im_ready) state_next = last_word ? FULL : IDLE;
      FULL:    state_next = FULL;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Outputs decoded from state
  always_comb begin
    in_ready = (state_reg == IDLE);
    im_we    = (state_reg == EMIT);
    full     = (state_reg == FULL);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg    <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
    end else if (clear) begin
      pc_reg    <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= accept && !enc_ok;
      if (accept && enc_ok) wdata_reg <= enc_word;
      // pc holds at its top value rather than wrapping when DEPTH == 2**ADDR_W
      if ((state_reg == EMIT) && im_ready && !pc_inc[ADDR_W])
        pc_reg <= pc_inc[ADDR_W-1:0];
    end
  end

  assign pc       = pc_reg;
  assign im_addr  = pc_reg;
  assign im_wdata = wdata_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodes each kind, exercises stalls,
// illegal kinds, fill-to-full, clear and asynchronous reset mid-write.
module tb_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset, clear, in_valid, in_ready, im_we, im_ready, full, err;
  logic [3:0]        in_kind;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [15:0]       in_imm;
  logic [ADDR_W-1:0] in_target, im_addr, pc;
  logic [31:0]       im_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .im_ready(im_ready), .pc(pc), .full(full), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, stall imem for 'stall' cycles, then complete the write.
  task automatic send(input string tag, input logic [3:0] kind, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input logic [7:0] target, input int stall,
                      input logic [31:0] exp_word, input logic [7:0] exp_addr);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = target;
    tick();
    in_valid = 1'b0;
    chk({tag, ".im_we"},   32'(im_we),   32'd1);
    chk({tag, ".wdata"},   im_wdata,     exp_word);
    chk({tag, ".addr"},    32'(im_addr), 32'(exp_addr));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, ".hold_we"},    32'(im_we), 32'd1);
      chk({tag, ".hold_wdata"}, im_wdata,   exp_word);
    end
    im_ready = 1'b1;
    tick();
    im_ready = 1'b0;
    chk({tag, ".we_drop"}, 32'(im_we), 32'd0);
    chk({tag, ".pc"},      32'(pc),    32'(exp_addr) + 32'd1);
    $display("txn %s: kind=%0d addr=%0d word=%h", tag, kind, exp_addr, exp_word);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; im_ready = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    #1;
    chk("rst.im_we", 32'(im_we), 32'd0);
    chk("rst.pc", 32'(pc), 32'd0);
    chk("rst.wdata", im_wdata, 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    send("add",  4'd0, 5'd1,  5'd2,  5'd3,  16'h0000, 8'h00, 0, 32'h00221820, 8'd0);
    send("lw",   4'd5, 5'd4,  5'd5,  5'd9,  16'hFFFC, 8'h00, 3, 32'h8C85FFFC, 8'd1);

    // illegal kind: error pulse only
    in_valid = 1'b1; in_kind = 4'd12;
    tick();
    in_valid = 1'b0;
    chk("ill.err", 32'(err), 32'd1);
    chk("ill.im_we", 32'(im_we), 32'd0);
    chk("ill.pc", 32'(pc), 32'd2);
    chk("ill.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("ill.err_pulse", 32'(err), 32'd0);
    $display("txn illegal: kind=12 err pulsed");

    send("ori",  4'd4, 5'd2,  5'd3,  5'd0,  16'h1234, 8'h00, 0, 32'h34431234, 8'd2);
    send("sw",   4'd6, 5'd6,  5'd7,  5'd0,  16'h0008, 8'h00, 1, 32'hACC70008, 8'd3);
    send("addi", 4'd9, 5'd0,  5'd9,  5'd0,  16'hFFFF, 8'h00, 0, 32'h2009FFFF, 8'd4);
    send("beq",  4'd7, 5'd1,  5'd0,  5'd0,  16'h0000, 8'h02, 0, 32'h1020FFFC, 8'd5);
    send("j",    4'd8, 5'd0,  5'd0,  5'd0,  16'h0000, 8'h40, 0, 32'h08000040, 8'd6);
    send("sub",  4'd1, 5'd31, 5'd31, 5'd31, 16'h0000, 8'h00, 0, 32'h03FFF822, 8'd7);

    chk("full.full", 32'(full), 32'd1);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_kind = 4'd0;
    tick();
    in_valid = 1'b0;
    chk("full.no_we", 32'(im_we), 32'd0);
    chk("full.pc_hold", 32'(pc), 32'd8);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr.pc", 32'(pc), 32'd0);
    chk("clr.full", 32'(full), 32'd0);
    chk("clr.in_ready", 32'(in_ready), 32'd1);
    $display("txn clear: pc=%0d", pc);

    // async reset while a write is stalled
    in_valid = 1'b1; in_kind = 4'd3; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
    tick();
    in_valid = 1'b0;
    chk("rstw.we_before", 32'(im_we), 32'd1);
    chk("rstw.or_word", im_wdata, 32'h00221825);
    #2 reset = 1'b1;
    #1;
    chk("rstw.we_async", 32'(im_we), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rstw.pc", 32'(pc), 32'd0);
    chk("rstw.in_ready", 32'(in_ready), 32'd1);
    $display("txn reset_mid_write: im_we=%0d pc=%0d", im_we, pc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
